// File: rtl/io_device_fifo.sv
// Circular FIFO device buffer with a threshold-driven DMA burst FSM and chip-selected CPU access.
// Optional status word / overflow clear behind IODEV_STATUS_EN.
module io_device_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int INDEX_W = 9,
  parameter int THRESH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INDEX_W-1:0]         index,
  input  logic                       io_write,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rdata_valid,
  input  logic                       ack,
  output logic                       gpio,
  input  logic                       ext_valid,
  input  logic [DATA_W-1:0]          ext_data,
  output logic                       ext_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR  = (AW+1)'(THRESH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, slot;
  logic [AW:0]       burst_len, burst_nxt;
  logic              cs, ack_rd, cs_rd, cs_wr, push, pop, stat_sel;
  logic [DATA_W-1:0] status_word;
  logic              unused_idx;

  assign cs     = index[INDEX_W-1];
  assign ack_rd = ack && !io_write;
  assign cs_rd  = cs && !io_write;
  assign cs_wr  = cs && io_write;
  assign slot   = rd_ptr + index[AW-1:0];

`ifdef IODEV_STATUS_EN
  assign stat_sel = index[INDEX_W-2];
`else
  assign stat_sel = 1'b0;
`endif
  assign unused_idx = ^index[INDEX_W-2:AW];

  assign status_word = DATA_W'({overflow, state, count});
  assign ext_ready   = (count != FULL);
  assign push        = ext_valid && ext_ready;
  assign pop         = (state == XFER) && ack_rd && !cs && (count != '0);

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_len;
    case (state)
      IDLE: if (count >= THR) state_nxt = REQ;
      REQ: begin
        if (ack_rd && !cs) begin
          burst_nxt = count;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!ack_rd) begin
          state_nxt = REQ;
        end else if (!cs) begin
          if (count == '0) begin
            state_nxt = DONE;
          end else begin
            burst_nxt = burst_len - ONE;
            // Leave after the last word of the burst or when this pop drains the buffer.
            if (burst_len == ONE || (count == ONE && !push)) state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = (count >= THR) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_len   <= '0;
      gpio        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_len <= burst_nxt;
      gpio      <= (state_nxt == REQ) || (state_nxt == XFER);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (ext_valid && !ext_ready) overflow <= 1'b1;
      else if (cs_wr && stat_sel)  overflow <= 1'b0;
      rdata_valid <= cs_rd || pop;
      if (cs_rd)    rdata <= stat_sel ? status_word : mem[slot];
      else if (pop) rdata <= mem[rd_ptr];
    end
  end

  // CS write is placed last so it wins over a same-slot push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext_data;
    if (cs_wr && !stat_sel) mem[slot] <= wdata;
  end

endmodule

// File: tb/tb_io_device_fifo.sv
// Directed bench for io_device_fifo: push/threshold, burst drain, full/overflow,
// CS access and stall, ack drop, asynchronous reset mid-burst.
module tb_io_device_fifo;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 32;
  localparam int INDEX_W = 9;
  localparam int AW      = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst;
  logic [INDEX_W-1:0] index;
  logic               io_write;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               ack;
  logic               gpio;
  logic               ext_valid;
  logic [DATA_W-1:0]  ext_data;
  logic               ext_ready;
  logic [AW:0]        count;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  io_device_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INDEX_W(INDEX_W), .THRESH(1)) dut (
    .clk(clk), .rst(rst), .index(index), .io_write(io_write), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .ack(ack), .gpio(gpio),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; index = '0; io_write = 1'b0; wdata = '0;
    ack = 1'b0; ext_valid = 1'b0; ext_data = '0;
    #2;
    check("rst_rdata", rdata, 0);
    check("rst_valid", rdata_valid, 0);
    check("rst_gpio", gpio, 0);
    check("rst_ready", ext_ready, 1);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    tick; tick; rst = 1'b0; tick;

    // push A,B,C
    ext_valid = 1'b1; ext_data = 32'hA; tick;
    check("push1_count", count, 1);
    check("push1_gpio", gpio, 0);
    ext_data = 32'hB; tick;
    check("gpio_rise", gpio, 1);
    check("push2_count", count, 2);
    ext_data = 32'hC; tick;
    check("push3_count", count, 3);
    ext_valid = 1'b0;

    // burst drain
    ack = 1'b1; tick;
    check("req2xfer_valid", rdata_valid, 0);
    tick;
    check("pop_a", rdata, 32'hA);
    check("pop_a_valid", rdata_valid, 1);
    check("pop_a_count", count, 2);
    check("xfer_gpio", gpio, 1);
    tick;
    check("pop_b", rdata, 32'hB);
    tick;
    check("pop_c", rdata, 32'hC);
    check("pop_c_count", count, 0);
    check("done_gpio", gpio, 0);
    ack = 1'b0; tick;
    check("idle_gpio", gpio, 0);
    check("idle_valid", rdata_valid, 0);
    check("rdata_hold", rdata, 32'hC);

    // fill to full (pointers start at 3, so the writes wrap)
    ext_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ext_data = 32'h100 + 32'(i);
      tick;
    end
    check("full_count", count, 32);
    check("full_ready", ext_ready, 0);
    check("full_ovf0", overflow, 0);
    ext_data = 32'hBAD; tick;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 32);
    ext_valid = 1'b0;

`ifdef IODEV_STATUS_EN
    index = 9'h180; tick;
    check("status_word", rdata, 32'h160);
    check("status_valid", rdata_valid, 1);
    io_write = 1'b1; tick;
    io_write = 1'b0; index = '0;
    check("ovf_clear", overflow, 0);
`endif

    // CS read of head, CS write/read at the last slot
    index = 9'h100; tick;
    check("cs_head", rdata, 32'h100);
    index = 9'h11F; io_write = 1'b1; wdata = 32'hC0FFEE; tick;
    io_write = 1'b0; tick;
    check("cs_wr_rd", rdata, 32'hC0FFEE);
    check("cs_count", count, 32);
    index = '0;

    // burst from full, push-with-pop refused, CS stall
    ack = 1'b1; tick;
    ext_valid = 1'b1; ext_data = 32'hBAD2; tick;
    check("full_pop0", rdata, 32'h100);
    check("full_pushpop_count", count, 31);
    ext_valid = 1'b0; tick;
    check("full_pop1", rdata, 32'h101);
    check("full_pop1_count", count, 30);
    index = 9'h102; tick;
    check("cs_stall_rdata", rdata, 32'h104);
    check("cs_stall_count", count, 30);
    index = '0; tick;
    check("resume_pop2", rdata, 32'h102);
    tick;
    check("resume_pop3", rdata, 32'h103);
    check("resume_count", count, 28);

    // async reset mid-burst, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_gpio", gpio, 0);
    check("arst_ready", ext_ready, 1);
    check("arst_rdata", rdata, 0);
    check("arst_valid", rdata_valid, 0);
    check("arst_ovf", overflow, 0);
    ack = 1'b0;
    tick; rst = 1'b0; tick;

    // ack drop after 2 of 5
    ext_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ext_data = 32'hE0 + 32'(i);
      tick;
    end
    ext_valid = 1'b0;
    check("five_count", count, 5);
    ack = 1'b1; tick;
    tick;
    check("drop_pop0", rdata, 32'hE0);
    tick;
    check("drop_pop1", rdata, 32'hE1);
    ack = 1'b0; tick;
    check("drop_valid", rdata_valid, 0);
    check("drop_gpio", gpio, 1);
    check("drop_count", count, 3);
    ack = 1'b1; tick;
    tick;
    check("resume_e2", rdata, 32'hE2);
    tick;
    check("resume_e3", rdata, 32'hE3);
    tick;
    check("resume_e4", rdata, 32'hE4);
    check("resume_e4_count", count, 0);
    check("resume_done_gpio", gpio, 0);
    ack = 1'b0; tick; tick;
    check("final_gpio", gpio, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
